// File: rtl/my_counter_pkg.sv
// Shared types and constants for the down-counter/timer family.
package my_counter_pkg;

   localparam int DEFAULT_N = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COUNT   = 2'd1,
      EXPIRED = 2'd2
   } cnt_state_t;

endpackage

// File: rtl/my_prescaler.sv
// Divides enabled sysclk cycles down to one tick every PRESCALE enabled cycles.
module my_prescaler #(
   parameter int PRESCALE = 1
) (
   input  logic sysclk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tick
);

   generate
      if (PRESCALE <= 1) begin : g_direct
         assign tick = en;
      end else begin : g_divide
         localparam int W = $clog2(PRESCALE);
         localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

         logic [W-1:0] cnt;

         // Counter freezes while en is low so a paused timer resumes mid-period.
         always_ff @(posedge sysclk) begin
            if (reset || clr) begin
               cnt <= '0;
            end else if (en) begin
               if (cnt == LAST) begin
                  cnt <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
         end

         assign tick = en && (cnt == LAST);
      end
   endgenerate

endmodule

// File: rtl/my_down_counter.sv
// Loadable down-counter/timer with terminal-count pulse and optional auto-reload.
module my_down_counter
   import my_counter_pkg::*;
#(
   parameter int N        = DEFAULT_N,
   parameter int PRESCALE = 1
) (
   input  logic         sysclk,
   input  logic         reset,
   input  logic         sys_clr,
   input  logic         load,
   input  logic [N-1:0] d,
   input  logic         en,
   input  logic         auto_reload,
   output logic [N-1:0] q,
   output logic         tc,
   output logic         busy
);

   localparam logic [N-1:0] ONE = N'(1);

   cnt_state_t   state, state_next;
   logic [N-1:0] q_next;
   logic [N-1:0] reload, reload_next;
   logic         tc_next;
   logic         tick;

   my_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
      .sysclk (sysclk),
      .reset  (reset),
      .clr    (sys_clr | load),
      .en     (en),
      .tick   (tick)
   );

   always_ff @(posedge sysclk) begin
      if (reset) begin
         state  <= IDLE;
         q      <= '0;
         reload <= '0;
         tc     <= 1'b0;
      end else begin
         state  <= state_next;
         q      <= q_next;
         reload <= reload_next;
         tc     <= tc_next;
      end
   end

   // Priority: clear, then load (which also aborts a run on its terminal tick), then a count step.
   always_comb begin
      state_next  = state;
      q_next      = q;
      reload_next = reload;
      tc_next     = 1'b0;
      if (sys_clr) begin
         state_next = IDLE;
         q_next     = '0;
      end else if (load) begin
         q_next      = d;
         reload_next = d;
         state_next  = (d != '0) ? COUNT : EXPIRED;
      end else if (state == COUNT && tick) begin
         if (q == ONE) begin
            tc_next = 1'b1;
            if (auto_reload) begin
               q_next = reload;
            end else begin
               q_next     = '0;
               state_next = EXPIRED;
            end
         end else if (q != '0) begin
            q_next = q - ONE;
         end
      end
   end

   assign busy = (state == COUNT);

endmodule

// File: tb/tb_my_down_counter.sv
// Directed bench for my_down_counter: PRESCALE=1 instance plus a PRESCALE=4 instance on shared stimulus.
module tb_my_down_counter;

   logic       sysclk = 1'b0;
   logic       reset, sys_clr, load, en, auto_reload;
   logic [7:0] d;
   logic [7:0] q1, q4;
   logic       tc1, tc4, busy1, busy4;

   int compared   = 0;
   int mismatched = 0;

   always #5 sysclk = ~sysclk;

   my_down_counter #(.N(8), .PRESCALE(1)) dut1 (
      .sysclk(sysclk), .reset(reset), .sys_clr(sys_clr), .load(load), .d(d),
      .en(en), .auto_reload(auto_reload), .q(q1), .tc(tc1), .busy(busy1)
   );

   my_down_counter #(.N(8), .PRESCALE(4)) dut4 (
      .sysclk(sysclk), .reset(reset), .sys_clr(sys_clr), .load(load), .d(d),
      .en(en), .auto_reload(auto_reload), .q(q4), .tc(tc4), .busy(busy4)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Drive one cycle of inputs, let the edge happen, then sample 1 time unit later.
   task automatic applyStimulus(input logic rst, input logic clr, input logic ld,
                                input logic [7:0] dv, input logic e, input logic ar);
      reset = rst; sys_clr = clr; load = ld; d = dv; en = e; auto_reload = ar;
      @(posedge sysclk);
      #1;
   endtask

   task automatic checkState(input string tag, input logic [7:0] eq, input logic etc, input logic ebusy);
      checkOutput({tag, ".q"},    32'(q1),    32'(eq));
      checkOutput({tag, ".tc"},   32'(tc1),   32'(etc));
      checkOutput({tag, ".busy"}, 32'(busy1), 32'(ebusy));
   endtask

   initial begin
      logic [7:0] seq5 [5];
      logic [7:0] seqAr [6];
      logic [7:0] expQ;
      seq5  = '{8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
      seqAr = '{8'd2, 8'd1, 8'd3, 8'd2, 8'd1, 8'd3};

      reset = 1'b1; sys_clr = 1'b0; load = 1'b0; d = '0; en = 1'b0; auto_reload = 1'b0;
      #2;
      applyStimulus(1, 0, 0, 8'd0, 0, 0);
      applyStimulus(1, 0, 0, 8'd0, 0, 0);
      checkState("reset", 8'd0, 0, 0);
      checkOutput("reset.q4", 32'(q4), 32'd0);

      // Plain count 5 down to 0 with a single tc pulse.
      applyStimulus(0, 0, 1, 8'd5, 1, 0);
      checkState("load5", 8'd5, 0, 1);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 0, 0, 8'd0, 1, 0);
         checkState($sformatf("cnt5[%0d]", i), seq5[i], (i == 4), (i != 4));
      end
      applyStimulus(0, 0, 0, 8'd0, 1, 0);
      checkState("expiredHold", 8'd0, 0, 0);

      // Auto-reload 3,2,1,3,...
      applyStimulus(0, 0, 1, 8'd3, 1, 1);
      checkState("load3ar", 8'd3, 0, 1);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(0, 0, 0, 8'd0, 1, 1);
         checkState($sformatf("ar[%0d]", i), seqAr[i], (i == 2 || i == 5), 1);
      end
      applyStimulus(0, 0, 0, 8'd0, 1, 1);
      applyStimulus(0, 0, 0, 8'd0, 1, 1);
      checkState("arAtOne", 8'd1, 0, 1);
      // Load on the would-be terminal tick wins and suppresses tc.
      applyStimulus(0, 0, 1, 8'd9, 1, 1);
      checkState("loadOnTc", 8'd9, 0, 1);

      // Pause at q=4 for five cycles, then resume.
      applyStimulus(0, 0, 1, 8'd6, 1, 0);
      applyStimulus(0, 0, 0, 8'd0, 1, 0);
      applyStimulus(0, 0, 0, 8'd0, 1, 0);
      checkState("prePause", 8'd4, 0, 1);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 0, 0, 8'd0, 0, 0);
         checkState($sformatf("pause[%0d]", i), 8'd4, 0, 1);
      end
      applyStimulus(0, 0, 0, 8'd0, 1, 0);
      checkState("resume", 8'd3, 0, 1);

      // Reset held 3 cycles mid-count.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 0, 0, 8'd0, 1, 0);
         checkState($sformatf("midReset[%0d]", i), 8'd0, 0, 0);
      end

      // Zero load goes straight to EXPIRED without a pulse.
      applyStimulus(0, 0, 1, 8'd0, 1, 0);
      checkState("load0", 8'd0, 0, 0);
      applyStimulus(0, 0, 0, 8'd0, 1, 0);
      checkState("load0Next", 8'd0, 0, 0);

      // sys_clr beats a simultaneous load.
      applyStimulus(0, 0, 1, 8'd7, 1, 0);
      checkState("load7", 8'd7, 0, 1);
      applyStimulus(0, 1, 1, 8'd9, 1, 0);
      checkState("clrVsLoad", 8'd0, 0, 0);
      applyStimulus(0, 0, 0, 8'd0, 1, 0);
      checkState("clrIdle", 8'd0, 0, 0);

      // Full range from 255.
      applyStimulus(0, 0, 1, 8'd255, 1, 0);
      checkState("load255", 8'd255, 0, 1);
      for (int i = 1; i <= 255; i++) begin
         applyStimulus(0, 0, 0, 8'd0, 1, 0);
         expQ = 8'(255 - i);
         if (q1 !== expQ || i == 255)
            checkState($sformatf("full[%0d]", i), expQ, (i == 255), (i != 255));
      end

      // PRESCALE=4 instance: 2 for 4 cycles, 1 for 4, then 0 with tc.
      applyStimulus(0, 0, 1, 8'd2, 1, 0);
      checkOutput("ps4.load", 32'(q4), 32'd2);
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(0, 0, 0, 8'd0, 1, 0);
         expQ = (k < 4) ? 8'd2 : (k < 8) ? 8'd1 : 8'd0;
         checkOutput($sformatf("ps4.q[%0d]", k), 32'(q4), 32'(expQ));
         checkOutput($sformatf("ps4.tc[%0d]", k), 32'(tc4), 32'(k == 8));
         checkOutput($sformatf("ps4.busy[%0d]", k), 32'(busy4), 32'(k != 8));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
